// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory address/data, hazard and redirect inputs, IF/ID outputs.
// Purely combinational wiring, no latency of its own.
// No flow control on this bus; stall is the only hold mechanism.
//
// Signals:
//   instr_in      : word returned by instruction memory for pc
//   stall         : hold pc and IF/ID
//   branch_taken  : redirect request from execute
//   branch_target : redirect byte address
//   pc            : current fetch address
//   if_id_pc      : PC of registered instruction
//   if_id_instr   : registered instruction
//   if_id_valid   : IF/ID holds a real instruction
//   target_err    : sticky bad-branch-target flag
interface fetch_stage_if;
  logic [31:0] instr_in;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        target_err;

  // Fetch stage side
  modport master (
    input  instr_in, stall, branch_taken, branch_target,
    output pc, if_id_pc, if_id_instr, if_id_valid, target_err
  );

  // Memory / pipeline side
  modport slave (
    output instr_in, stall, branch_taken, branch_target,
    input  pc, if_id_pc, if_id_instr, if_id_valid, target_err
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and registers {pc, instr_in} into IF/ID.
// Latency: word addressed by pc appears on if_id_instr one edge later; a branch costs one bubble.
// Backpressure: stall holds pc and IF/ID; branch_taken overrides stall.
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : fetch_stage_if.master (see interface for signal list)
//
// Optional macro FETCH_HALT_ON_ZERO_EN: a fetched all-zero word is not issued and the
// stage parks in HALT until a branch or reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef FETCH_HALT_ON_ZERO_EN
  localparam logic [1:0] ST_HALT = 2'd2;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        target_err_q, target_err_d;

  logic [31:0] tgt_aligned;
  logic        tgt_misaligned;
  logic        tgt_out_of_range;
  logic [31:0] redirect_pc;
  logic [31:0] pc_inc;

  // Out-of-range takes precedence over misalignment: the aligned address is checked first.
  assign tgt_aligned      = {bus.branch_target[31:2], 2'b00};
  assign tgt_misaligned   = (bus.branch_target[1:0] != 2'b00);
  assign tgt_out_of_range = (tgt_aligned >= IMEM_BYTES);
  assign redirect_pc      = tgt_out_of_range ? RESET_PC : tgt_aligned;

  // Wrap at the end of instruction memory so pc never leaves its address space.
  assign pc_inc = ((pc_q + 32'd4) == IMEM_BYTES) ? 32'd0 : (pc_q + 32'd4);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    target_err_d  = target_err_q;

    case (state_q)
      // One idle cycle so memory can present the word at RESET_PC.
      ST_BOOT: begin
        if_id_valid_d = 1'b0;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        if (bus.branch_taken) begin
          pc_d          = redirect_pc;
          if_id_pc_d    = 32'd0;
          if_id_instr_d = 32'd0;
          if_id_valid_d = 1'b0;
          target_err_d  = target_err_q | tgt_misaligned | tgt_out_of_range;
        end else if (!bus.stall) begin
          if_id_pc_d    = pc_q;
          if_id_instr_d = bus.instr_in;
          if_id_valid_d = 1'b1;
          pc_d          = pc_inc;
`ifdef FETCH_HALT_ON_ZERO_EN
          // Zero word: capture it but do not issue, and park.
          if (bus.instr_in == 32'd0) begin
            if_id_valid_d = 1'b0;
            pc_d          = pc_q;
            state_d       = ST_HALT;
          end
`endif
        end
      end
`ifdef FETCH_HALT_ON_ZERO_EN
      ST_HALT: begin
        if (bus.branch_taken) begin
          pc_d          = redirect_pc;
          if_id_pc_d    = 32'd0;
          if_id_instr_d = 32'd0;
          if_id_valid_d = 1'b0;
          target_err_d  = target_err_q | tgt_misaligned | tgt_out_of_range;
          state_d       = ST_RUN;
        end
      end
`endif
      default: begin
        state_d       = ST_BOOT;
        pc_d          = RESET_PC;
        if_id_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= 32'd0;
      if_id_valid_q <= 1'b0;
      target_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      target_err_q  <= target_err_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.target_err  = target_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus a zero-word sequence.
// Inputs applied on the falling edge, outputs sampled 1 time unit after the rising edge.
// Memory model returns a pc-tagged word, optionally zero at pc 12.
module tb_fetch_stage;

  logic clock;
  logic reset;
  logic zero_mode;
  int   total;
  int   bad;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.instr_in = (zero_mode && (bus.pc == 32'd12)) ? 32'd0 : (32'hC0DE_0000 | bus.pc);

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic        e_vld;
    logic        e_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst_n, logic stall, logic br, logic [31:0] tgt,
                              logic [31:0] e_pc, logic [31:0] e_ipc, logic [31:0] e_instr,
                              logic e_vld, logic e_err);
    vec_t v;
    v.rst_n = rst_n; v.stall = stall; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_instr = e_instr; v.e_vld = e_vld; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic stall, input logic br, input logic [31:0] tgt);
    @(negedge clock);
    reset             = rst_n;
    bus.stall         = stall;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                           input logic [31:0] e_instr, input logic e_vld, input logic e_err);
    check({tag, " pc"},    bus.pc,                   e_pc);
    check({tag, " ipc"},   bus.if_id_pc,             e_ipc);
    check({tag, " instr"}, bus.if_id_instr,          e_instr);
    check({tag, " valid"}, {31'd0, bus.if_id_valid}, {31'd0, e_vld});
    check({tag, " err"},   {31'd0, bus.target_err},  {31'd0, e_err});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    zero_mode = 1'b0;
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;

    //              rst stl br  tgt            pc             ipc            instr          v     e
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  32'h0,  32'h0,          1'b0, 1'b0); // reset
    vecs[1]  = mk(1'b0, 1'b1, 1'b1, 32'h40,  32'h0,  32'h0,  32'h0,          1'b0, 1'b0); // reset wins
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 32'h40,  32'h0,  32'h0,  32'h0,          1'b0, 1'b0); // boot ignores br/stall
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h4,  32'h0,  32'hC0DE_0000,  1'b1, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h8,  32'h4,  32'hC0DE_0004,  1'b1, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   32'h8,  32'h4,  32'hC0DE_0004,  1'b1, 1'b0); // stall x3
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   32'h8,  32'h4,  32'hC0DE_0004,  1'b1, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   32'h8,  32'h4,  32'hC0DE_0004,  1'b1, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'hC,  32'h8,  32'hC0DE_0008,  1'b1, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 32'h40,  32'h40, 32'h0,  32'h0,          1'b0, 1'b0); // branch beats stall
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h44, 32'h40, 32'hC0DE_0040,  1'b1, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b1, 32'h78,  32'h78, 32'h0,  32'h0,          1'b0, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h7C, 32'h78, 32'hC0DE_0078,  1'b1, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h0,  32'h7C, 32'hC0DE_007C,  1'b1, 1'b0); // wrap
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h4,  32'h0,  32'hC0DE_0000,  1'b1, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 1'b1, 32'h42,  32'h40, 32'h0,  32'h0,          1'b0, 1'b1); // misaligned
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h44, 32'h40, 32'hC0DE_0040,  1'b1, 1'b1); // sticky
    vecs[17] = mk(1'b1, 1'b0, 1'b1, 32'h200, 32'h0,  32'h0,  32'h0,          1'b0, 1'b1); // out of range
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 32'h0,   32'h4,  32'h0,  32'hC0DE_0000,  1'b1, 1'b1);
    vecs[19] = mk(1'b1, 1'b0, 1'b1, 32'h7E,  32'h7C, 32'h0,  32'h0,          1'b0, 1'b1); // misaligned, in range
    vecs[20] = mk(1'b1, 1'b0, 1'b1, 32'h203, 32'h0,  32'h0,  32'h0,          1'b0, 1'b1); // both: range wins
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 32'h0,   32'h0,  32'h0,  32'h0,          1'b0, 1'b1); // stall on bubble
    vecs[22] = mk(1'b0, 1'b1, 1'b1, 32'h40,  32'h0,  32'h0,  32'h0,          1'b0, 1'b0); // reset mid-stall/branch

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ipc, vecs[i].e_instr,
                vecs[i].e_vld, vecs[i].e_err);
    end

    // Zero word at pc 12
    zero_mode = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_all("z boot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_all("z pre", 32'hC, 32'h8, 32'hC0DE_0008, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_HALT_ON_ZERO_EN
    check_all("z halt", 32'hC, 32'hC, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, k[0], 1'b0, 32'h0);
      check_all($sformatf("z hold%0d", k), 32'hC, 32'hC, 32'h0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check_all("z redirect", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_all("z resume", 32'h4, 32'h0, 32'hC0DE_0000, 1'b1, 1'b0);
`else
    check_all("z issue", 32'h10, 32'hC, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_all("z next", 32'h14, 32'h10, 32'hC0DE_0010, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
